// File: rtl/board_uart_tx.sv
// ---------------------------------------------------------------------------
// board_uart_tx
//
// Streams the packed 16-tile game board to a host as a framed UART byte
// sequence (8N1, LSB first, line idles high). A frame goes out automatically
// whenever the (stable) board differs from the last board sent, or when a
// re-send is requested.
//
// Frame: HEADER, tile bytes 0..15, checksum (XOR of the 16 tile bytes).
// Each tile byte is the 16-bit exponent saturated to 8 bits.
//
// Optional feature macro: BOARD_TX_CRLF_EN
//   defined   -> 8'h0D, 8'h0A are appended after the checksum (20 bytes)
//   undefined -> 18-byte frame, no CR/LF logic
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   board_in    packed board [0:255]; tile i is board_in[i*16 +: 16]
//   send_req    one-cycle pulse forcing a frame even if the board is unchanged
//   tx          UART transmit line
//   busy        high from the header start bit through the last stop bit
//   frame_done  one-cycle pulse in the cycle after the final stop bit
// ---------------------------------------------------------------------------
module board_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:255] board_in,
  input  logic         send_req,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

`ifdef BOARD_TX_CRLF_EN
  localparam logic [4:0] LAST_BYTE = 5'd19;
`else
  localparam logic [4:0] LAST_BYTE = 5'd17;
`endif
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t       state_q;
  logic [15:0]  bit_cnt_q;
  logic [2:0]   bit_idx_q;
  logic [4:0]   byte_idx_q;
  logic         pending_q;
  logic [0:255] shadow_q;
  logic [0:255] prev_q;
  logic [0:255] frame_q;
  logic         tx_q;
  logic         busy_q;
  logic         done_q;

  logic [7:0]   tile_byte [16];
  logic [7:0]   csum_d;
  logic [7:0]   cur_byte_d;
  logic         stable_d;
  logic         trigger_d;
  logic         bit_end_d;

  // Saturate each 16-bit exponent of the latched frame to one byte.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_tile
      logic [15:0] tile_val;
      assign tile_val      = frame_q[gi*16 +: 16];
      assign tile_byte[gi] = (|tile_val[15:8]) ? 8'hFF : tile_val[7:0];
    end
  endgenerate

  always_comb begin
    csum_d = 8'h00;
    for (int i = 0; i < 16; i++) begin
      csum_d = csum_d ^ tile_byte[i];
    end
  end

  // Byte currently on the wire, selected by the frame position.
  always_comb begin
    cur_byte_d = HEADER;
    case (byte_idx_q)
      5'd0:    cur_byte_d = HEADER;
      5'd17:   cur_byte_d = csum_d;
`ifdef BOARD_TX_CRLF_EN
      5'd18:   cur_byte_d = 8'h0D;
      5'd19:   cur_byte_d = 8'h0A;
`endif
      default: cur_byte_d = tile_byte[4'(byte_idx_q - 5'd1)];
    endcase
  end

  // The board is updated from a button-edge domain; only snapshot it once it
  // has held the same value for a full cycle.
  assign stable_d  = (board_in == prev_q);
  assign trigger_d = stable_d && ((board_in != shadow_q) || pending_q || send_req);
  assign bit_end_d = (bit_cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      prev_q     <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      prev_q <= board_in;
      done_q <= 1'b0;

      // Requests during a frame merge into a single pending re-send.
      if (state_q != IDLE && send_req) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trigger_d) begin
            frame_q    <= board_in;
            shadow_q   <= board_in;
            pending_q  <= 1'b0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            bit_cnt_q  <= BIT_RELOAD;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end else if (send_req) begin
            pending_q <= 1'b1;
          end
        end

        START: begin
          if (bit_end_d) begin
            bit_cnt_q <= BIT_RELOAD;
            bit_idx_q <= '0;
            tx_q      <= cur_byte_d[0];
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end

        DATA: begin
          if (bit_end_d) begin
            bit_cnt_q <= BIT_RELOAD;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte_d[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end

        STOP: begin
          // End of the stop bit doubles as the next-byte decision, so bytes
          // follow each other with no idle gap.
          if (bit_end_d) begin
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 5'd1;
              bit_cnt_q  <= BIT_RELOAD;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              byte_idx_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/board_uart_tx.md
Name: board_uart_tx

Overview:
- Consumer side of the game board bus: samples the packed 16-tile board word and streams it to a host as a framed UART byte sequence.
- Transmits automatically whenever the board changes. A host or debug button can also force a re-send.
- Sits beside the display path, fed from the same board_out bus. Drives the FPGA UART TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- board_in  input  256  packed board, big-endian vector [0:255]. Tile i (i = row*4+col, 0..15) occupies board_in[i*16 +: 16]. Value is the log2 exponent; 0 means empty.
- send_req  input  1  single-cycle pulse that forces a frame even if the board is unchanged.
- tx  output  1  UART line, 8N1, LSB first, idles high.
- busy  output  1  high from the cycle tx drops for the header start bit through the last stop bit.
- frame_done  output  1  one-cycle pulse in the cycle after the final stop bit completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): on that edge tx=1, busy=0, frame_done=0, FSM=IDLE, bit counter=0, byte index=0, pending flag=0, shadow register=all zeros, previous-sample register=all zeros. Reset mid-frame aborts immediately; no partial byte is completed.
- Input qualification:
  - board_in is registered every cycle into prev_sample.
  - board_in counts as stable when board_in == prev_sample.
  - A snapshot is only taken from a stable board. This absorbs the button-edge-clocked update of the board.
- Trigger: in IDLE, start when the board is stable AND either (board_in != shadow) or pending=1 or send_req=1.
- On a trigger:
  - copy board_in into frame buffer and into shadow;
  - clear pending;
  - go to START on the next edge. tx goes low in the first START cycle, which is 1 cycle of latency after the trigger cycle.
- send_req while busy: sets pending (1-deep; extra requests merge). Serviced on return to IDLE.
- Frame, 18 bytes in order:
  - HEADER;
  - tile bytes 0..15;
  - checksum = XOR of the 16 tile bytes (header excluded).
- Tile byte: the exponent saturated to 8 bits. Values > 255 send 8'hFF; otherwise the low 8 bits.
- FSM: IDLE -> START (1 bit-time, tx=0) -> DATA (8 bit-times, bit0 first) -> STOP (1 bit-time, tx=1) -> NEXT.
  - NEXT is a 0-cycle decision, folded into the last STOP cycle.
  - If the byte index is below the last byte: increment the index and go to START.
  - Otherwise: go to IDLE and pulse frame_done.
- Bit timing: each bit lasts exactly CLKS_PER_BIT cycles, counted by a down-counter reloaded at every bit boundary. No idle gap between bytes inside a frame. One frame = 18*10*CLKS_PER_BIT cycles of busy.
- Board changes during a frame do not affect the frame in flight. On return to IDLE the board is compared with shadow; if different, the next frame starts with one IDLE cycle of minimum gap.
- frame_done and a new trigger may coincide: the trigger is evaluated in the IDLE cycle after frame_done.
- A zero board after reset matches shadow, so nothing is sent unless send_req is asserted.

Optional Feature:
- Macro BOARD_TX_CRLF_EN.
- Defined: after the checksum, two extra bytes 8'h0D, 8'h0A are sent with identical framing. Frame = 20 bytes; busy lasts 20*10*CLKS_PER_BIT cycles; the checksum still covers tile bytes only.
- Undefined: 18-byte frame exactly as above; no CR/LF logic is synthesised.

Test Plan:
- All tests use CLKS_PER_BIT=4 (18-byte frame = 720 cycles).
- Reset, board_in=0, no send_req for 2000 cycles -> tx=1, busy=0, frame_done never pulses.
- Set tile0=1, tile15=2, others 0 -> bytes A5,01,00x14,02,03. busy high exactly 720 cycles; tx low 1 cycle after the stable-detect cycle; one frame_done pulse.
- Set tile5=16'h0123, others 0 -> tile5 byte FF, checksum FF. Set tile5=16'h0080 -> byte 80, checksum 80.
- Change tile3 from 1 to 2 at cycle 100 of a frame -> the current frame carries 01 for tile3. A second frame carrying 02 starts 1 IDLE cycle after frame_done; no third frame follows.
- Board unchanged, send_req pulsed in IDLE -> an identical frame is re-sent. Pulse send_req 3 times while busy -> exactly one extra frame.
- Assert rst_n=0 for 1 cycle mid-DATA of byte 7 with the board nonzero -> tx=1 and busy=0 on the next edge. After release, a full 18-byte frame of the current board starts (shadow was cleared).
